fp_add_arbiter: RTL and testbench

Shares one pipelined floating-point adder between N requesters: the CPU FAD/FSB/FLT/FLOOR path plus auxiliary engines such as display and DMA math helpers. Each requester issues a single operation. The arbiter latches that requester's operands and sequences the adder's run/stall protocol, then returns the 32-bit result with a one-cycle acknowledge. It sits between the requesters and the adder instance. The adder's own state counter and handshake are not modified.

---
 rtl/fp_add_arbiter_if.sv | 31 +++
 rtl/fp_add_arbiter.sv | 164 ++++++++++++++++
 tb/tb_fp_add_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_add_arbiter_if.sv
// Requester-side and adder-side signal bundle for fp_add_arbiter.
// slave: the arbiter's view; master: the environment (requesters plus adder).
interface fp_add_arbiter_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0]    req;
  logic [N-1:0]    u_in;
  logic [N-1:0]    v_in;
  logic [32*N-1:0] x_in;
  logic [32*N-1:0] y_in;
  logic [N-1:0]    ack;
  logic [31:0]     z_out;
  logic            busy;
  logic            fa_run;
  logic            fa_u;
  logic            fa_v;
  logic [31:0]     fa_x;
  logic [31:0]     fa_y;
  logic            fa_stall;
  logic [31:0]     fa_z;

  modport slave (
    input  req, u_in, v_in, x_in, y_in, fa_stall, fa_z,
    output ack, z_out, busy, fa_run, fa_u, fa_v, fa_x, fa_y
  );

  modport master (
    output req, u_in, v_in, x_in, y_in, fa_stall, fa_z,
    input  ack, z_out, busy, fa_run, fa_u, fa_v, fa_x, fa_y
  );
endinterface

// File: rtl/fp_add_arbiter.sv
// Shares one pipelined FP adder between N requesters; one op per grant, one-cycle ack.
// FPARB_RR_EN selects round-robin arbitration; otherwise fixed priority (lowest index).
module fp_add_arbiter #(
  parameter int unsigned N = 4
) (
  input logic             clk,
  input logic             rst,
  fp_add_arbiter_if.slave bus
);
  localparam int unsigned IW = $clog2(N);

  typedef enum logic [0:0] {st_idle, st_run} state_t;

  state_t        state;
  logic [IW-1:0] gnt;
`ifdef FPARB_RR_EN
  logic [IW-1:0] ptr;
`endif
  logic [N-1:0]  ack_q;
  logic [31:0]   z_q;
  logic          run_q;
  logic          u_q;
  logic          v_q;
  logic [31:0]   x_q;
  logic [31:0]   y_q;

  logic [N-1:0]  elig;
  logic [N-1:0]  elig_nx;
  logic [IW-1:0] win;
  logic [IW-1:0] win_nx;
  logic [IW-1:0] sel;
  logic [31:0]   sel_x;
  logic [31:0]   sel_y;
  logic          sel_u;
  logic          sel_v;

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
    logic [N-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

`ifdef FPARB_RR_EN
  // Search starts just after the last grant and wraps.
  function automatic logic [IW-1:0] pick(input logic [N-1:0] e, input logic [IW-1:0] base);
    logic [IW-1:0] w;
    logic          found;
    int            idx;
    w     = base;
    found = 1'b0;
    for (int k = 1; k <= int'(N); k++) begin
      idx = (int'(base) + k) % int'(N);
      if (!found && e[idx]) begin
        w     = IW'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction
`else
  function automatic logic [IW-1:0] pick(input logic [N-1:0] e);
    logic [IW-1:0] w;
    w = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (e[i]) w = IW'(i);
    end
    return w;
  endfunction
`endif

  always_comb begin
    // A requester acked this cycle cannot have dropped req yet.
    elig    = bus.req & ~ack_q;
    elig_nx = elig & ~onehot(gnt);
`ifdef FPARB_RR_EN
    win     = pick(elig, ptr);
    win_nx  = pick(elig_nx, ptr);
`else
    win     = pick(elig);
    win_nx  = pick(elig_nx);
`endif
    sel   = (state == st_idle) ? win : win_nx;
    sel_x = '0;
    sel_y = '0;
    sel_u = 1'b0;
    sel_v = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (sel == IW'(i)) begin
        sel_x = bus.x_in[32*i +: 32];
        sel_y = bus.y_in[32*i +: 32];
        sel_u = bus.u_in[i];
        sel_v = bus.v_in[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= st_idle;
      gnt   <= '0;
`ifdef FPARB_RR_EN
      ptr   <= '0;
`endif
      ack_q <= '0;
      z_q   <= '0;
      run_q <= 1'b0;
      u_q   <= 1'b0;
      v_q   <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      ack_q <= '0;
      case (state)
        st_idle: begin
          if (|elig) begin
            run_q <= 1'b1;
            u_q   <= sel_u;
            v_q   <= sel_v;
            x_q   <= sel_x;
            y_q   <= sel_y;
            gnt   <= win;
`ifdef FPARB_RR_EN
            ptr   <= win;
`endif
            state <= st_run;
          end else begin
            run_q <= 1'b0;
          end
        end
        st_run: begin
          if (run_q && !bus.fa_stall) begin
            z_q   <= bus.fa_z;
            ack_q <= onehot(gnt);
            // Back-to-back: the adder counter wraps 3->0 with run held high.
            if (|elig_nx) begin
              u_q <= sel_u;
              v_q <= sel_v;
              x_q <= sel_x;
              y_q <= sel_y;
              gnt <= win_nx;
`ifdef FPARB_RR_EN
              ptr <= win_nx;
`endif
            end else begin
              run_q <= 1'b0;
              state <= st_idle;
            end
          end
        end
        default: state <= st_idle;
      endcase
    end
  end

  assign bus.ack    = ack_q;
  assign bus.z_out  = z_q;
  assign bus.busy   = (state == st_run);
  assign bus.fa_run = run_q;
  assign bus.fa_u   = u_q;
  assign bus.fa_v   = v_q;
  assign bus.fa_x   = x_q;
  assign bus.fa_y   = y_q;
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter with a 4-cycle adder model and a lookup-table result.
module tb_fp_add_arbiter;
  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fp_add_arbiter_if #(.N(N)) bus ();

  fp_add_arbiter #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   errors = 0;
  int   checks = 0;
  logic stall_force = 1'b0;
  logic [1:0] fst = 2'd0;

  // Adder model: stalls in its states 0..2, result valid in state 3.
  always @(posedge clk) begin
    if (!bus.fa_run) fst <= 2'd0;
    else if (fst != 2'd3) fst <= fst + 2'd1;
    else if (!bus.fa_stall) fst <= 2'd0;
  end

  function automatic logic [31:0] fadd_model(input logic [31:0] x, input logic [31:0] y,
                                             input logic u, input logic v);
    logic [31:0] r;
    if (u) begin
      case (x)
        32'd5:   r = 32'h40A0_0000;
        32'd3:   r = 32'h4040_0000;
        default: r = 32'hDEAD_0001;
      endcase
    end else if (v) begin
      r = 32'hDEAD_0002;
    end else begin
      case ({x, y})
        {32'h3F80_0000, 32'h4000_0000}: r = 32'h4040_0000;
        {32'h3F80_0000, 32'h3F80_0000}: r = 32'h4000_0000;
        {32'h4000_0000, 32'h4000_0000}: r = 32'h4080_0000;
        {32'h3F00_0000, 32'h3F00_0000}: r = 32'h3F80_0000;
        {32'h4040_0000, 32'h3F80_0000}: r = 32'h4080_0000;
        default:                        r = 32'hBAD0_BAD0;
      endcase
    end
    return r;
  endfunction

  assign bus.fa_stall = stall_force | (bus.fa_run & (fst != 2'd3));
  assign bus.fa_z     = fadd_model(bus.fa_x, bus.fa_y, bus.fa_u, bus.fa_v);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] x, input logic [31:0] y,
                        input logic u, input logic v);
    bus.x_in[32*i +: 32] = x;
    bus.y_in[32*i +: 32] = y;
    bus.u_in[i]          = u;
    bus.v_in[i]          = v;
  endtask

  // Issue from idle; cycle 1 is the first cycle after the grant edge.
  task automatic run_single(input int i, input logic [31:0] x, input logic [31:0] y,
                            input logic u, input logic v, input logic [31:0] exp_z,
                            input string tag);
    int          runs;
    int          ack_c;
    logic [N-1:0] ack_v;
    logic [N-1:0] exp_ack;
    logic [31:0] z;
    logic        u_all;
    runs    = 0;
    ack_c   = 0;
    ack_v   = '0;
    z       = '0;
    u_all   = 1'b1;
    exp_ack = '0;
    exp_ack[i] = 1'b1;
    set_op(i, x, y, u, v);
    bus.req[i] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) begin
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        bus.x_in[32*i +: 32] = 32'hFFFF_FFFF;
      end
      if (bus.fa_run) begin
        runs++;
        if (bus.fa_u !== u) u_all = 1'b0;
      end
      if (bus.ack != '0) begin
        ack_c      = c;
        ack_v      = bus.ack;
        z          = bus.z_out;
        bus.req[i] = 1'b0;
        break;
      end
    end
    check({tag, "_ack_cycle"}, 32'(ack_c), 32'd5);
    check({tag, "_ack"}, 32'(ack_v), 32'(exp_ack));
    check({tag, "_run_cycles"}, 32'(runs), 32'd4);
    check({tag, "_z"}, z, exp_z);
    check({tag, "_u_held"}, 32'(u_all), 32'd1);
    tick();
    check({tag, "_ack_pulse"}, 32'(bus.ack), 32'd0);
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          first_ack;
    int          second_ack;
    logic        run5;
    logic        run6;
    logic [N-1:0] ack6;
    int          bad;
    int          ack_c;
    logic [N-1:0] ack_v;
    logic [31:0] z;
    int          n;
    int          run_gap;
    int          multi_bits;
    int          ack_idx[4];
    int          ack_cyc[4];
    logic [31:0] ack_z[4];
    int          exp_order[4];
    logic [31:0] zt[4];

    bus.req  = '0;
    bus.u_in = '0;
    bus.v_in = '0;
    bus.x_in = '0;
    bus.y_in = '0;
    #2 rst = 1'b1;
    tick();
    tick();
    check("rst_fa_run", 32'(bus.fa_run), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_z", bus.z_out, 32'd0);
    check("rst_fa_x", bus.fa_x, 32'd0);
    check("rst_fa_uv", {30'd0, bus.fa_u, bus.fa_v}, 32'd0);
    rst = 1'b0;
    tick();

    run_single(1, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 32'h4040_0000, "single");
    run_single(2, 32'd5, 32'd0, 1'b1, 1'b0, 32'h40A0_0000, "flt");

    // Requester 0 holds req through its ack.
    set_op(0, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0);
    bus.req[0] = 1'b1;
    first_ack  = 0;
    second_ack = 0;
    run5 = 1'b1;
    run6 = 1'b1;
    ack6 = '1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 5) run5 = bus.fa_run;
      if (c == 6) begin
        run6 = bus.fa_run;
        ack6 = bus.ack;
      end
      if (bus.ack[0]) begin
        if (first_ack == 0) first_ack = c;
        else begin
          second_ack = c;
          bus.req[0] = 1'b0;
          break;
        end
      end
    end
    check("hold_first_ack", 32'(first_ack), 32'd5);
    check("hold_no_reack", 32'(ack6), 32'd0);
    check("hold_idle_c5", 32'(run5), 32'd0);
    check("hold_idle_c6", 32'(run6), 32'd0);
    check("hold_second_ack", 32'(second_ack), 32'd11);
    tick();

    // Externally forced stall freezes the adder operands.
    set_op(3, 32'h3F00_0000, 32'h3F00_0000, 1'b0, 1'b0);
    bus.req[3] = 1'b1;
    tick();
    stall_force = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.fa_x !== 32'h3F00_0000 || bus.fa_y !== 32'h3F00_0000 || bus.fa_u !== 1'b0 ||
          bus.fa_v !== 1'b0 || bus.ack !== '0 || bus.fa_run !== 1'b1) bad++;
    end
    stall_force = 1'b0;
    ack_c = 0;
    ack_v = '0;
    z     = '0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (bus.ack != '0) begin
        ack_c = c;
        ack_v = bus.ack;
        z     = bus.z_out;
        bus.req[3] = 1'b0;
        break;
      end
    end
    check("stall_frozen", 32'(bad), 32'd0);
    check("stall_ack_delay", 32'(ack_c), 32'd1);
    check("stall_ack", 32'(ack_v), 32'h8);
    check("stall_z", z, 32'h3F80_0000);
    tick();

    // Reset during cycle 3 of a run.
    set_op(1, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0);
    bus.req[1] = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst_fa_run", 32'(bus.fa_run), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_fa_x", bus.fa_x, 32'd0);
    check("midrst_fa_y", bus.fa_y, 32'd0);
    check("midrst_z", bus.z_out, 32'd0);
    bus.req = '0;
    tick();
    tick();
    check("midrst_no_ack", 32'(bus.ack), 32'd0);
    rst = 1'b0;
    tick();
    run_single(1, 32'h4040_0000, 32'h3F80_0000, 1'b0, 1'b0, 32'h4080_0000, "post_rst");

    // All four requesting together, each dropping req on its ack.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
`ifdef FPARB_RR_EN
    exp_order = '{1, 2, 3, 0};
`else
    exp_order = '{0, 1, 2, 3};
`endif
    zt = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h3F80_0000};
    set_op(0, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0);
    set_op(1, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0);
    set_op(2, 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0);
    set_op(3, 32'h3F00_0000, 32'h3F00_0000, 1'b0, 1'b0);
    bus.req    = '1;
    n          = 0;
    run_gap    = 0;
    multi_bits = 0;
    for (int k = 0; k < 4; k++) begin
      ack_idx[k] = -1;
      ack_cyc[k] = 0;
      ack_z[k]   = '0;
    end
    for (int c = 1; c <= 40 && n < 4; c++) begin
      tick();
      if (c <= 16 && !bus.fa_run) run_gap++;
      if (bus.ack != '0) begin
        if (!$onehot(bus.ack)) multi_bits++;
        for (int i = 0; i < int'(N); i++) begin
          if (bus.ack[i]) begin
            ack_idx[n] = i;
            bus.req[i] = 1'b0;
          end
        end
        ack_cyc[n] = c;
        ack_z[n]   = bus.z_out;
        n++;
      end
    end
    check("multi_count", 32'(n), 32'd4);
    check("multi_run_gap", 32'(run_gap), 32'd0);
    check("multi_onehot", 32'(multi_bits), 32'd0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("multi_order%0d", k), 32'(ack_idx[k]), 32'(exp_order[k]));
      check($sformatf("multi_cycle%0d", k), 32'(ack_cyc[k]), 32'(5 + 4 * k));
      check($sformatf("multi_z%0d", k), ack_z[k], zt[exp_order[k]]);
    end
    bus.req = '0;
    tick();
    tick();
    check("final_idle", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
